// File: rtl/cp0_timer_if.sv
// Bus between the MEM stage and CP0: mfc0/mtc0 access, exception inputs,
// interrupt lines and the handler-entry outputs.
interface cp0_timer_if #(
    parameter int NUM_HWINT = 5
);
    logic [4:0]           A1;
    logic [4:0]           A2;
    logic [31:0]          WD;
    logic                 WE;
    logic [31:0]          PC;
    logic                 BD;
    logic [4:0]           excCode;
    logic [31:0]          badVAddr;
    logic [NUM_HWINT-1:0] HWInt;
    logic                 EXLReset;
    logic                 intExcReq;
    logic [31:0]          EPC;
    logic [31:0]          RD;
    logic                 timerInt;
    logic [NUM_HWINT-1:0] intAck;

    // CP0 side
    modport slave (
        input  A1, A2, WD, WE, PC, BD, excCode, badVAddr, HWInt, EXLReset,
        output intExcReq, EPC, RD, timerInt, intAck
    );

    // pipeline / peripheral side
    modport master (
        output A1, A2, WD, WE, PC, BD, excCode, badVAddr, HWInt, EXLReset,
        input  intExcReq, EPC, RD, timerInt, intAck
    );
endinterface

// File: rtl/cp0_timer.sv
// Coprocessor 0 with configurable hardware interrupt lines, a prescaled
// Count/Compare timer, BadVAddr capture and a per-line interrupt acknowledge.
module cp0_timer #(
    parameter int          NUM_HWINT = 5,
    parameter int          CNT_DIV   = 1,
    parameter logic [31:0] PRID_VAL  = 32'h20373944
) (
    input  logic         clk,
    input  logic         reset,
    cp0_timer_if.slave   bus
);
    // Writable IM bits: one per external line plus the timer bit (15).
    localparam logic [5:0] IM_MASK = {1'b1, 5'((32'd1 << NUM_HWINT) - 32'd1)};
    localparam logic [7:0] DIV_MAX = 8'(CNT_DIV - 1);

    logic [5:0]           r_im;
    logic                 r_exl;
    logic                 r_ie;
    logic                 r_bd;
    logic                 r_ti;
    logic [4:0]           r_exccode;
    logic [NUM_HWINT-1:0] r_iphw;
    logic [31:0]          r_epc;
    logic [31:0]          r_badv;
    logic [31:0]          r_count;
    logic [31:0]          r_compare;
    logic [7:0]           r_presc;
    logic [NUM_HWINT-1:0] r_intack;

    logic [4:0]           w_hw5;
    logic [4:0]           w_iphw5;
    logic [5:0]           w_pend;
    logic                 w_int_req;
    logic                 w_exc_req;
    logic                 w_entry;
    logic                 w_tick;
    logic [31:0]          w_count_inc;
    logic                 w_wr_sr;
    logic                 w_wr_epc;
    logic                 w_wr_count;
    logic                 w_wr_compare;
    logic [NUM_HWINT-1:0] w_ack_sel;
    logic [31:0]          w_sr;
    logic [31:0]          w_cause;

    // Pending sources aligned to IP[15:10]; live HWInt drives the request.
    always_comb begin
        w_hw5   = '0;
        w_iphw5 = '0;
        w_hw5[NUM_HWINT-1:0]   = bus.HWInt;
        w_iphw5[NUM_HWINT-1:0] = r_iphw;
        w_pend    = {r_ti, w_hw5};
        w_int_req = r_ie & ~r_exl & (|(r_im & w_pend));
        w_exc_req = (bus.excCode != 5'd0) & ~r_exl;
        w_entry   = w_int_req | w_exc_req;
    end

    assign w_wr_sr      = bus.WE && (bus.A2 == 5'd12);
    assign w_wr_epc     = bus.WE && (bus.A2 == 5'd14);
    assign w_wr_count   = bus.WE && (bus.A2 == 5'd9);
    assign w_wr_compare = bus.WE && (bus.A2 == 5'd11);
    assign w_tick       = (r_presc == DIV_MAX);
    assign w_count_inc  = r_count + 32'd1;

    // Highest-index enabled and pending external line gets the acknowledge.
    always_comb begin
        w_ack_sel = '0;
        for (int i = 0; i < NUM_HWINT; i++) begin
            if (bus.HWInt[i] && r_im[i]) begin
                w_ack_sel    = '0;
                w_ack_sel[i] = 1'b1;
            end
        end
    end

    // Register read mux (mfc0).
    always_comb begin
        w_sr    = {16'b0, r_im, 8'b0, r_exl, r_ie};
        w_cause = {r_bd, r_ti, 14'b0, r_ti, w_iphw5, 3'b0, r_exccode, 2'b0};
        case (bus.A1)
            5'd8:    bus.RD = r_badv;
            5'd9:    bus.RD = r_count;
            5'd11:   bus.RD = r_compare;
            5'd12:   bus.RD = w_sr;
            5'd13:   bus.RD = w_cause;
            5'd14:   bus.RD = r_epc;
            5'd15:   bus.RD = PRID_VAL;
            default: bus.RD = 32'd0;
        endcase
    end

    // SR, Cause, EPC, BadVAddr and acknowledge; entry overrides eret and mtc0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_im      <= '0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_exccode <= '0;
            r_iphw    <= '0;
            r_epc     <= '0;
            r_badv    <= '0;
            r_intack  <= '0;
        end else begin
            r_iphw   <= bus.HWInt;
            r_intack <= w_int_req ? w_ack_sel : '0;
            if (w_entry) begin
                r_exl     <= 1'b1;
                r_bd      <= bus.BD;
                r_exccode <= w_int_req ? 5'd0 : bus.excCode;
                r_epc     <= bus.BD ? (bus.PC - 32'd4) : bus.PC;
                if (!w_int_req && (bus.excCode == 5'd4 || bus.excCode == 5'd5))
                    r_badv <= bus.badVAddr;
            end else begin
                if (w_wr_sr) begin
                    r_im  <= bus.WD[15:10] & IM_MASK;
                    r_ie  <= bus.WD[0];
                    r_exl <= bus.EXLReset ? 1'b0 : bus.WD[1];
                end else if (bus.EXLReset) begin
                    r_exl <= 1'b0;
                end
                if (w_wr_epc)
                    r_epc <= bus.WD;
            end
        end
    end

    // Prescaled Count, Compare and the timer-interrupt flag; a Compare write
    // clears TI even if the same tick would set it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_compare <= 32'hFFFF_FFFF;
            r_presc   <= '0;
            r_ti      <= 1'b0;
        end else begin
            if (w_wr_count) begin
                r_count <= bus.WD;
                r_presc <= '0;
            end else if (w_tick) begin
                r_count <= w_count_inc;
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 8'd1;
            end
            if (w_wr_compare)
                r_compare <= bus.WD;
            if (w_wr_compare)
                r_ti <= 1'b0;
            else if (!w_wr_count && w_tick && (w_count_inc == r_compare))
                r_ti <= 1'b1;
        end
    end

    assign bus.intExcReq = w_entry;
    assign bus.EPC       = r_epc;
    assign bus.timerInt  = r_ti;
    assign bus.intAck    = r_intack;
endmodule

// File: tb/tb_cp0_timer.sv
// Directed bench for cp0_timer: reset state, interrupt/exception entry,
// precedence rules, timer, acknowledge priority and Count wrap.
module tb_cp0_timer;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    cp0_timer_if #(.NUM_HWINT(5)) bus ();

    cp0_timer #(.NUM_HWINT(5), .CNT_DIV(1), .PRID_VAL(32'h20373944)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // advance one edge; inputs change and outputs are sampled 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
        bus.A1 = a;
        #1;
        chk(tag, bus.RD, exp);
    endtask

    task automatic idle();
        bus.WE = 1'b0; bus.A2 = 5'd0; bus.WD = '0; bus.BD = 1'b0;
        bus.excCode = '0; bus.HWInt = '0; bus.EXLReset = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.WE = 1'b1; bus.A2 = a; bus.WD = d;
        step();
        bus.WE = 1'b0;
    endtask

    task automatic eret();
        bus.EXLReset = 1'b1;
        step();
        bus.EXLReset = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        idle();
        bus.A1 = '0; bus.PC = '0; bus.badVAddr = '0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;

        // reset state
        rd(5'd12, "rst_sr", 32'h0);
        rd(5'd13, "rst_cause", 32'h0);
        rd(5'd14, "rst_epc", 32'h0);
        rd(5'd8,  "rst_badv", 32'h0);
        rd(5'd11, "rst_compare", 32'hFFFF_FFFF);
        rd(5'd15, "prid", 32'h2037_3944);
        rd(5'd3,  "unmapped", 32'h0);
        chk("rst_ti", 32'(bus.timerInt), 32'h0);
        chk("rst_ack", 32'(bus.intAck), 32'h0);
        chk("rst_req", 32'(bus.intExcReq), 32'h0);

        // SR write masking: only IM[15:10], EXL, IE stick
        mtc0(5'd12, 32'hFFFF_FC01);
        rd(5'd12, "sr_wr", 32'h0000_FC01);

        // hardware interrupt entry
        bus.HWInt = 5'b00001; bus.PC = 32'h3010; bus.BD = 1'b0;
        #1 chk("hw_req", 32'(bus.intExcReq), 32'h1);
        step();
        chk("hw_epc", bus.EPC, 32'h3010);
        chk("hw_ack", 32'(bus.intAck), 32'h1);
        chk("hw_req_masked", 32'(bus.intExcReq), 32'h0);
        rd(5'd12, "hw_sr", 32'h0000_FC03);
        rd(5'd13, "hw_cause", 32'h0000_0400);
        bus.HWInt = '0;
        step();
        chk("hw_ack_pulse", 32'(bus.intAck), 32'h0);
        eret();
        rd(5'd12, "eret_sr", 32'h0000_FC01);

        // AdEL in a delay slot
        bus.excCode = 5'd4; bus.BD = 1'b1; bus.PC = 32'h3024; bus.badVAddr = 32'h1003;
        #1 chk("adel_req", 32'(bus.intExcReq), 32'h1);
        step();
        bus.excCode = '0; bus.BD = 1'b0;
        chk("adel_epc", bus.EPC, 32'h3020);
        rd(5'd13, "adel_cause", 32'h8000_0010);
        rd(5'd8,  "adel_badv", 32'h1003);
        chk("adel_ack", 32'(bus.intAck), 32'h0);
        eret();

        // timer: Compare=5, Count=0 -> TI five edges after the Count write
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        chk("tmr_ti0", 32'(bus.timerInt), 32'h0);
        rd(5'd9, "tmr_cnt0", 32'd0);
        repeat (4) step();
        chk("tmr_ti4", 32'(bus.timerInt), 32'h0);
        rd(5'd9, "tmr_cnt4", 32'd4);
        step();
        chk("tmr_ti5", 32'(bus.timerInt), 32'h1);
        rd(5'd9, "tmr_cnt5", 32'd5);
        chk("tmr_req", 32'(bus.intExcReq), 32'h1);
        // timer-only entry while writing Compare (clears TI)
        bus.PC = 32'h5000;
        mtc0(5'd11, 32'h1234);
        chk("tmr_clr", 32'(bus.timerInt), 32'h0);
        chk("tmr_noack", 32'(bus.intAck), 32'h0);
        chk("tmr_epc", bus.EPC, 32'h5000);
        rd(5'd12, "tmr_sr", 32'h0000_FC03);
        rd(5'd13, "tmr_cause", 32'h0);
        eret();

        // interrupt + eret + mtc0 EPC in one cycle
        bus.HWInt = 5'b00001; bus.PC = 32'h3100; bus.EXLReset = 1'b1;
        bus.WE = 1'b1; bus.A2 = 5'd14; bus.WD = 32'h4000;
        step();
        idle();
        chk("prec_epc", bus.EPC, 32'h3100);
        rd(5'd12, "prec_sr", 32'h0000_FC03);
        eret();

        // interrupt beats simultaneous AdES
        bus.HWInt = 5'b00001; bus.excCode = 5'd5; bus.badVAddr = 32'hDEAD; bus.PC = 32'h3200;
        step();
        idle();
        rd(5'd13, "pri_cause", 32'h0000_0400);
        rd(5'd8,  "pri_badv", 32'h1003);
        eret();

        // two lines pending: highest index acknowledged
        bus.HWInt = 5'b01001;
        step();
        idle();
        chk("ack_hi", 32'(bus.intAck), 32'h8);
        eret();

        // Count wrap, no TI (Compare = 0x1234)
        mtc0(5'd9, 32'hFFFF_FFFF);
        rd(5'd9, "wrap_pre", 32'hFFFF_FFFF);
        step();
        rd(5'd9, "wrap_post", 32'h0);
        chk("wrap_ti", 32'(bus.timerInt), 32'h0);

        // loading Count with Compare never sets TI
        mtc0(5'd9, 32'h1234);
        chk("ld_eq_ti", 32'(bus.timerInt), 32'h0);
        step();
        rd(5'd9, "ld_eq_cnt", 32'h1235);
        chk("ld_eq_ti2", 32'(bus.timerInt), 32'h0);

        // TI set by counting into Compare
        mtc0(5'd9, 32'h1232);
        step();
        chk("cnt_ti_a", 32'(bus.timerInt), 32'h0);
        step();
        chk("cnt_ti_b", 32'(bus.timerInt), 32'h1);

        // reset mid-operation while an interrupt would be taken
        reset = 1'b1; bus.HWInt = 5'b00001; bus.PC = 32'h3300;
        step();
        chk("mrst_ack", 32'(bus.intAck), 32'h0);
        chk("mrst_epc", bus.EPC, 32'h0);
        chk("mrst_ti", 32'(bus.timerInt), 32'h0);
        rd(5'd12, "mrst_sr", 32'h0);
        rd(5'd11, "mrst_compare", 32'hFFFF_FFFF);
        reset = 1'b0; idle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
